// File: rtl/mat_interleave_tx.sv
// Holds two DIM x DIM matrices and streams them element-interleaved (A0,B0,A1,B1,...) on an AXI-Stream master.
// When DIM*DIM is a power of two, the write address carries one extra bit so that out-of-range indices can be represented.
module mat_interleave_tx #(
  parameter  int DIM    = 2,
  parameter  int DATA_W = 8,
  localparam int N      = DIM * DIM,
  localparam int AW     = $clog2(N + 1),
  localparam int KW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_e,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND_A = 2'd1, SEND_B = 2'd2, DONE = 2'd3} state_t;

  localparam logic [AW-1:0] N_ADDR = AW'(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   a_q [N];
  logic [DATA_W-1:0]   a_d [N];
  logic [DATA_W-1:0]   b_q [N];
  logic [DATA_W-1:0]   b_d [N];
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer_s;
  logic [KW-1:0]       wr_idx_s;

  assign xfer_s   = valid_q & m_axis_ready;
  assign wr_idx_s = i_wr_addr[KW-1:0];

  // Next-state logic: buffer writes, FSM sequencing and registered stream outputs
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wr_en && (i_wr_addr < N_ADDR)) begin
          if (i_wr_sel) b_d[wr_idx_s] = i_wr_data;
          else          a_d[wr_idx_s] = i_wr_data;
        end else begin
          a_d = a_q;
        end
        // a_d already holds a coincident write, so the first byte reflects it
        if (i_start) begin
          state_d = SEND_A;
          k_d     = '0;
          data_d  = a_d[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_A: begin
        if (xfer_s) begin
          state_d = SEND_B;
          data_d  = b_q[k_q];
          last_d  = (k_q == K_LAST);
        end else begin
          state_d = SEND_A;
        end
      end
      SEND_B: begin
        if (xfer_s && (k_q == K_LAST)) begin
          state_d = DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (xfer_s) begin
          state_d = SEND_A;
          k_d     = k_q + KW'(1);
          data_d  = a_q[k_q + KW'(1)];
          last_d  = 1'b0;
        end else begin
          state_d = SEND_B;
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; everything holds on edges without clock enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_clk_e) begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
